// File: rtl/dmem_lsu_if.sv
// Request/response and RAM-side signal bundle for the data-memory load/store unit.
// slave is the LSU view; master is the core plus RAM view.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_din, ram_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a synchronous-read word RAM without byte enables.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module dmem_lsu #(
  parameter int unsigned ADDR_W = 9
) (
  input logic        clk,
  input logic        rst_n,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StLdWait, StLdCap, StRmwWait, StRmwMerge, StRmwWrite, StStDone, StErr
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        legal_f3;
  logic        misalign;
  logic        req_bad;
  logic        req_sw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  assign accept = (state_q == StIdle) && bus.req_valid;

  always_comb begin
    legal_f3 = 1'b0;
    if (bus.req_we) begin
      legal_f3 = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal_f3 = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
  end

  assign misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign req_bad  = !legal_f3 || misalign;
  assign req_sw   = bus.req_we && (bus.req_funct3[1:0] == 2'b10);

  // Lane extraction and merge both work on the word the RAM returned for the latched address.
  always_comb begin
    ld_byte = bus.ram_dout[{off_q, 3'b000} +: 8];
    ld_half = bus.ram_dout[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.ram_dout;
    endcase
  end

  always_comb begin
    merged = bus.ram_dout;
    if (f3_q[0]) begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0;
      ram_addr_q  <= '0;
      ram_din_q   <= 32'h0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            state_d = StErr;
          end else if (!bus.req_we) begin
            state_d = StLdWait;
          end else if (req_sw) begin
            state_d = StStDone;
          end else begin
            state_d = StRmwWait;
          end
        end
      end
      StLdWait:   state_d = StLdCap;
      StRmwWait:  state_d = StRmwMerge;
      StRmwMerge: state_d = StRmwWrite;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    f3_d        = f3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d       = bus.req_funct3;
          off_d      = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          ram_addr_d = bus.req_addr[ADDR_W+1:2];
          if (!req_bad && req_sw) begin
            ram_din_d = bus.req_wdata;
            ram_we_d  = 1'b1;
          end
        end
      end
      StLdCap: begin
        rsp_rdata_d = ld_ext;
        rsp_valid_d = 1'b1;
      end
      StRmwMerge: begin
        ram_din_d = merged;
        ram_we_d  = 1'b1;
      end
      StRmwWrite, StStDone: rsp_valid_d = 1'b1;
      StErr: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_we    = ram_we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 512x32 sync-read RAM model and a response scoreboard.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(9)) bus ();

  dmem_lsu #(.ADDR_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 32'h0;
  logic [31:0] we_din = 32'h0;
  logic [31:0] cur_rd = 32'h0;
  int          prev_lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ram_we) begin
      we_cnt++;
      we_addr = 32'(bus.ram_addr);
      we_din  = bus.ram_din;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, ".err"}, 32'(bus.rsp_err), 32'(e.err));
        check({e.tag, ".rdata"}, bus.rsp_rdata, e.rdata);
        check({e.tag, ".cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic err,
                       input logic [31:0] data, input int lat, input bit b2b);
    int   waited;
    exp_t e;
    waited         = 0;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    if (b2b) @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check({tag, ".ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (b2b) begin
      check({tag, ".busy_cycles"}, 32'(waited), 32'(prev_lat));
      check({tag, ".accept_on_rsp"}, 32'(bus.rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    e.rdata = (!we && !err) ? data : cur_rd;
    cur_rd  = e.rdata;
    e.err   = err;
    e.cyc   = cyc + lat;
    e.tag   = tag;
    sb.push_back(e);
    prev_lat = lat;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, ".rsp_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int we_base;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    #12;
    check("rst.ram_we", 32'(bus.ram_we), 32'd0);
    check("rst.ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst.ram_din", bus.ram_din, 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SW then LW at word 4
    issue("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, 1'b0);
    wait_done("sw10");
    check("sw10.we_cnt", 32'(we_cnt), 32'd1);
    check("sw10.we_addr", we_addr, 32'd4);
    check("sw10.we_din", we_din, 32'hDEADBEEF);
    issue("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b0);
    wait_done("lw10");

    // SB into lane 1 is a single read-modify-write pulse
    issue("sb11", 1'b1, 3'b000, 32'h11, 32'h000000A5, 1'b0, 32'h0, 3, 1'b0);
    wait_done("sb11");
    check("sb11.we_cnt", 32'(we_cnt), 32'd2);
    check("sb11.we_din", we_din, 32'hDEADA5EF);
    issue("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADA5EF, 2, 1'b0);
    wait_done("lw10b");

    issue("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFA5, 2, 1'b0);
    wait_done("lb11");
    issue("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000A5, 2, 1'b0);
    wait_done("lbu11");
    issue("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 1'b0);
    wait_done("lh12");
    issue("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 2, 1'b0);
    wait_done("lhu12");
    issue("lb10", 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2, 1'b0);
    wait_done("lb10");

    // Error cases: no RAM write, rdata held
    we_base = we_cnt;
    issue("lw12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    wait_done("lw12_mis");
    issue("sh13_mis", 1'b1, 3'b001, 32'h13, 32'h0000BEEF, 1'b1, 32'h0, 1, 1'b0);
    wait_done("sh13_mis");
    issue("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    wait_done("ld_f3_011");
    issue("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    wait_done("st_f3_100");
    check("err.no_write", 32'(we_cnt), 32'(we_base));

    // Back-to-back with req_valid held high
    issue("b2b_sw", 1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0, 32'h0, 1, 1'b0);
    issue("b2b_lw", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h12345678, 2, 1'b1);
    issue("b2b_sb", 1'b1, 3'b000, 32'h41, 32'h0000009A, 1'b0, 32'h0, 3, 1'b1);
    wait_done("b2b");
    issue("b2b_chk", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h12349A78, 2, 1'b0);
    wait_done("b2b_chk");

    // Address wrap: 0x800 aliases word 0
    issue("sw800", 1'b1, 3'b010, 32'h800, 32'hCAFEF00D, 1'b0, 32'h0, 1, 1'b0);
    wait_done("sw800");
    check("sw800.we_addr", we_addr, 32'd0);
    issue("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1'b0);
    wait_done("lw0");

    // Reset during RMW_WRITE must drop the write
    issue("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'h0, 1, 1'b0);
    wait_done("sw20");
    issue("sh20", 1'b1, 3'b001, 32'h20, 32'h0000BEEF, 1'b0, 32'h0, 3, 1'b0);
    bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.ram_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sh20.reach_write", 32'(bus.ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("sh20.rst_we_drop", 32'(bus.ram_we), 32'd0);
    check("sh20.rst_valid", 32'(bus.rsp_valid), 32'd0);
    sb.delete();
    cur_rd = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst.rdata", bus.rsp_rdata, 32'd0);
    issue("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11223344, 2, 1'b0);
    wait_done("lw20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the RV32I core's memory stage and the 512x32 synchronous-read data RAM. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. It performs sign or zero extension on loads. Because the RAM has no byte enables, it performs read-modify-write for sub-word stores. It also flags misaligned and illegal requests.

Parameters:
ADDR_W, 9, RAM word-address width; word index = req_addr[ADDR_W+1:2]; higher address bits ignored (aliasing).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high iff FSM in IDLE; transfer on req_valid & req_ready at rising edge
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_err  out  1  valid with rsp_valid; misaligned or illegal funct3
rsp_rdata  out  32  load result, held until next load completes
ram_addr  out  ADDR_W  registered RAM word address
ram_din  out  32  registered RAM write data
ram_we  out  1  registered RAM write enable
ram_dout  in  32  RAM read data (valid one edge after ram_addr sampled)

Behaviour:
- Reset (async, immediate): state IDLE; outputs ram_we, ram_addr, ram_din, rsp_valid, rsp_err and rsp_rdata all 0.
- States: IDLE, LD_WAIT, LD_CAP, RMW_WAIT, RMW_MERGE, RMW_WRITE, ST_DONE, ERR.
- Acceptance edge E0, from IDLE:
  - Latch funct3, byte offset addr[1:0] and wdata.
  - ram_addr <= word index.
- Legality:
  - Loads allow funct3 in {000,001,010,100,101}; stores allow {000,001,010}.
  - Misaligned: H/HU/SH with addr[0]=1; W with addr[1:0]!=0.
  - Illegal or misaligned -> ERR; no RAM write.
  - At E1: rsp_valid=1, rsp_err=1, rsp_rdata unchanged, then IDLE.
- Load (latency 2):
  - E0 -> LD_WAIT with ram_we=0.
  - E1: RAM samples address -> LD_CAP.
  - E2: rsp_rdata <= extract(ram_dout), rsp_valid=1, rsp_err=0 -> IDLE.
- Extraction is little-endian:
  - Byte lane = ram_dout[8*off+7 : 8*off]; half lane = ram_dout[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- SW (latency 1):
  - E0: ram_din <= wdata, ram_we <= 1 -> ST_DONE.
  - E1: ram_we <= 0, rsp_valid=1 -> IDLE.
- SB/SH (latency 3):
  - E0 -> RMW_WAIT with ram_we=0.
  - E1 -> RMW_MERGE.
  - E2: ram_din <= ram_dout with the addressed lane replaced by wdata[7:0] or wdata[15:0], ram_we <= 1 -> RMW_WRITE.
  - E3: ram_we <= 0, rsp_valid=1 -> IDLE.
- Outside writes, ram_din holds its value; ram_addr holds the last address.
- rsp_valid and rsp_err are single-cycle pulses. rsp_rdata changes only on successful load completion.
- Back-to-back: req_ready is high during the rsp_valid cycle, so a new request may be accepted at the edge that ends it. There are no idle bubbles beyond that.
- req_valid while not ready is ignored. Requests are not queued; the requester holds them.
- The RAM is private to this block. No other write path exists, so the read-to-write window of an RMW cannot be corrupted.
- Reset mid-operation:
  - The request is abandoned and no rsp_valid is issued.
  - Reset asserted before E3 of an RMW or before E1 of SW drops ram_we asynchronously, so the write is not committed and RAM content is unchanged.
  - Other words are never affected.
- Address wrap: req_addr 0x800 aliases word 0 when ADDR_W=9.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ram_we pulse at word 4; LW rsp_rdata=0xDEADBEEF two cycles after acceptance, rsp_err=0.
- After previous, SB addr 0x11 wdata 0x000000A5, then LW 0x10 -> word reads 0xDEADA5EF; SB rsp_valid exactly 3 cycles after acceptance, single ram_we pulse.
- Word 4 = 0xDEADA5EF: LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- LW 0x12, SH 0x13, load funct3=011 -> each rsp_valid with rsp_err=1 one cycle after acceptance, ram_we never asserted, rsp_rdata unchanged.
- req_valid held high with SW, LW, SB issued back-to-back -> req_ready low in every busy cycle; each acceptance coincides with the prior rsp_valid cycle; final data correct.
- SH 0x20 (word holds 0x11223344) with rst_n pulled low during RMW_WRITE before E3 -> ram_we drops immediately; no rsp_valid; LW 0x20 after reset returns 0x11223344.
